// File: rtl/sprite_line_renderer_pkg.sv
// Shared video definitions for the sprite line buffer writer.
// Line buffer geometry, sprite pixel format and renderer state encoding.
// Pixel colour extraction from a 4-plane sprite row lives here as a helper.
package sprite_line_renderer_pkg;

  localparam int LB_DEPTH    = 256;
  localparam int LB_DATA_W   = 8;
  localparam int LB_IDX_W    = $clog2(LB_DEPTH);
  localparam int PIX_PER_SPR = 8;
  localparam int SPR_PAT_W   = 4 * PIX_PER_SPR;

  localparam logic [LB_DATA_W-1:0] SPR_MARK_DEF    = 8'h10;
  localparam logic [LB_DATA_W-1:0] CLEAR_VALUE_DEF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT,
    ST_READ,
    ST_CHECK
  } rend_state_t;

  // Pattern is {plane3,plane2,plane1,plane0}; pixel 0 is the MSB of each plane.
  function automatic logic [3:0] pix_colour(input logic [SPR_PAT_W-1:0] pat,
                                            input logic [2:0] i);
    logic [2:0] b;
    logic [7:0] p0, p1, p2, p3;
    b  = 3'd7 - i;
    p0 = pat[7:0];
    p1 = pat[15:8];
    p2 = pat[23:16];
    p3 = pat[31:24];
    return {p3[b], p2[b], p1[b], p0[b]};
  endfunction

endpackage

// File: rtl/sprite_line_renderer.sv
// Sprite line writer: clears the bank under construction, then draws sprite rows with read-check-write.
// Latency: 256 cycles to clear, 2 cycles per sprite pixel (16 per unclipped row), buffer read is 1 cycle.
// Backpressure: spr_ready only in WAIT and never in a line_start cycle; a line_start drops any sprite in flight.
module sprite_line_renderer
  import sprite_line_renderer_pkg::*;
#(
  parameter logic [LB_DATA_W-1:0] CLEAR_VALUE = CLEAR_VALUE_DEF,
  parameter logic [LB_DATA_W-1:0] SPR_MARK    = SPR_MARK_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 line_start,
  output logic                 linesel,
  input  logic                 spr_valid,
  output logic                 spr_ready,
  input  logic [LB_IDX_W-1:0]  spr_x,
  input  logic [SPR_PAT_W-1:0] spr_pattern,
  output logic [LB_IDX_W-1:0]  lb_idx,
  input  logic [LB_DATA_W-1:0] lb_rddata,
  output logic [LB_DATA_W-1:0] lb_wrdata,
  output logic                 lb_wren,
  output logic                 collision,
  input  logic                 coll_clr,
  output logic                 busy
);

  rend_state_t          r_state;
  rend_state_t          w_state_nxt;
  logic [LB_IDX_W-1:0]  r_idx;
  logic [2:0]           r_i;
  logic [LB_IDX_W-1:0]  r_x;
  logic [SPR_PAT_W-1:0] r_pat;
  logic                 r_linesel;
  logic                 r_collision;

  logic [3:0]           w_colour;
  logic                 w_opaque;
  logic                 w_occupied;
  logic                 w_draw;
  logic                 w_hit;
  logic                 w_accept;
  logic [LB_IDX_W:0]    w_next_pix;
  logic                 w_last;
  logic                 w_unused_rd;

  // Only the colour nibble decides occupancy; the palette bits are ignored.
  assign w_unused_rd = ^lb_rddata[LB_DATA_W-1:4];

  assign w_colour   = pix_colour(r_pat, r_i);
  assign w_opaque   = |w_colour;
  assign w_occupied = |lb_rddata[3:0];
  assign w_draw     = (r_state == ST_CHECK) && w_opaque && !w_occupied;
  assign w_hit      = (r_state == ST_CHECK) && w_opaque && w_occupied;
  assign w_accept   = spr_valid && spr_ready;
  // Position of the following pixel; bit 8 set means it falls off the right edge.
  assign w_next_pix = {1'b0, r_x} + {6'b0, r_i} + 9'd1;
  assign w_last     = (r_i == 3'(PIX_PER_SPR - 1)) || w_next_pix[LB_IDX_W];

  assign linesel   = r_linesel;
  assign lb_idx    = r_idx;
  assign collision = r_collision;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; line_start overrides everything and restarts the clear.
  always_comb begin
    w_state_nxt = r_state;
    if (line_start) begin
      w_state_nxt = ST_CLEAR;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_CLEAR: if (r_idx == LB_IDX_W'(LB_DEPTH - 1)) w_state_nxt = ST_WAIT;
        ST_WAIT:  if (w_accept) w_state_nxt = ST_READ;
        ST_READ:  w_state_nxt = ST_CHECK;
        ST_CHECK: w_state_nxt = w_last ? ST_WAIT : ST_READ;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the registered state; the CHECK write depends on the buffer read data.
  always_comb begin
    spr_ready = (r_state == ST_WAIT) && !line_start;
    busy      = (r_state == ST_CLEAR) || (r_state == ST_READ) || (r_state == ST_CHECK);
    lb_wren   = (r_state == ST_CLEAR) || w_draw;
    lb_wrdata = '0;
    if (r_state == ST_CLEAR) lb_wrdata = CLEAR_VALUE;
    else if (w_draw)         lb_wrdata = SPR_MARK | {4'b0, w_colour};
  end

  // Address counter, sprite capture and bank select.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_linesel <= 1'b0;
      r_idx     <= '0;
      r_i       <= '0;
      r_x       <= '0;
      r_pat     <= '0;
    end else if (line_start) begin
      r_linesel <= !r_linesel;
      r_idx     <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: r_idx <= r_idx + 8'd1;
        ST_WAIT: begin
          if (w_accept) begin
            r_x   <= spr_x;
            r_pat <= spr_pattern;
            r_i   <= '0;
            r_idx <= spr_x;
          end
        end
        ST_CHECK: begin
          r_i   <= r_i + 3'd1;
          r_idx <= w_next_pix[LB_IDX_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Sticky collision flag; a new hit wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_collision <= 1'b0;
    else if (w_hit)    r_collision <= 1'b1;
    else if (coll_clr) r_collision <= 1'b0;
  end

endmodule
